approx_add_sweep_ctrl: RTL and testbench
========================================

// Module: approx_add_sweep_ctrl
// PURPOSE
//  Sequencer that characterises one approximate unsigned adder instance.
//  Sweeps every operand pair (A,B) exhaustively and drives them into the adder.
//  Captures the adder sum, compares it with the exact A+B and accumulates error statistics.
//  Streams each {A,B} -> O result as a LUT entry over a valid/ready port to the LUT writer.
// PARAMETERS
//  W      8   operand width; the adder under test has W-bit inputs and a (W+1)-bit output
//  LAT    0   adder pipeline depth in cycles (0 = combinational adder)
//  ACC_W  32  width of the sum-of-absolute-error accumulator; must be >= 3W+1
// PORTS
//  clk        in   1      clock; all state updates on the rising edge
//  rst        in   1      synchronous reset, active-high
//  start      in   1      1-cycle request to begin a sweep; sampled only in IDLE or DONE
//  busy       out  1      high while a sweep is in progress
//  done       out  1      high from sweep completion until the next accepted start or rst
//  dut_a      out  W      operand A to the adder under test (registered)
//  dut_b      out  W      operand B to the adder under test (registered)
//  dut_o      in   W+1    sum returned by the adder under test
//  lut_valid  out  1      LUT entry valid
//  lut_ready  in   1      LUT writer accepts the entry
//  lut_addr   out  2W     entry address = {A,B}
//  lut_data   out  W+1    captured dut_o for that address
//  ep_cnt     out  2W+1   count of vectors where dut_o != A+B
//  wce        out  W+1    maximum |dut_o - (A+B)| seen so far
//  sae        out  ACC_W  sum of |dut_o - (A+B)| over all vectors so far
// BEHAVIOUR
//  Reset values: busy=0, done=0, lut_valid=0. dut_a, dut_b, lut_addr, lut_data,
//   ep_cnt, wce and sae are all 0. State = IDLE.
//  States: IDLE, DRIVE, EMIT, DONE.
//  IDLE/DONE + start -> DRIVE.
//   - Clear ep_cnt, wce, sae and done.
//   - Load dut_a=0, dut_b=0. Set busy=1.
//  DRIVE: lasts exactly LAT+1 cycles. Operands are held stable throughout.
//   - On the last DRIVE cycle, capture dut_o into lut_data and set lut_addr={dut_a,dut_b}.
//   - On the same edge, update the statistics from e = |dut_o - (dut_a+dut_b)|.
//     The exact sum is computed at W+1 bits; the difference is unsigned magnitude.
//     If e != 0, then ep_cnt += 1.
//     wce = max(wce, e).
//     sae += e (zero-extended).
//   - Then go to EMIT with lut_valid=1.
//  EMIT: lut_valid held at 1; lut_addr and lut_data held stable until lut_valid && lut_ready.
//   - On that handshake edge, lut_valid=0.
//   - If {dut_a,dut_b} == all ones: go to DONE, busy=0, done=1.
//   - Otherwise, increment {dut_a,dut_b} as one 2W-bit counter (B is the LSBs, B wraps into A)
//     and go to DRIVE.
//  Throughput: LAT+2 cycles per vector when lut_ready is held high.
//   Full sweep = 2^(2W)*(LAT+2) cycles from the start edge to the done edge.
//  start while busy: ignored, with no effect on state, counters or statistics.
//  Statistics are visible and monotonic during the sweep. They hold their final value in DONE.
//  rst mid-sweep: all outputs and state return to reset values on that edge. No partial
//   LUT entry is emitted after reset.
//  Saturation: none is needed. With ACC_W >= 3W+1, sae cannot overflow over a full sweep.
// TESTING
//  1 Exact adder model (dut_o=A+B), LAT=0, lut_ready=1, pulse start ->
//    65536 handshakes with lut_data=A+B, ep_cnt=0, wce=0, sae=0,
//    done high exactly 131072 cycles after start.
//  2 Model with dut_o=(A+B)&~1 ->
//    final ep_cnt=32768, wce=1, sae=32768; entry at addr 0x0304 carries data 0x006.
//  3 Model with dut_o=(A+B)&~1, lut_ready held low for 5 cycles at addr 0x0003 ->
//    lut_valid stays 1 with lut_addr=0x0003 and lut_data=0x002 stable.
//    dut_a/dut_b do not advance. The next entry is 0x0004 once ready rises.
//  4 Assert rst while lut_addr=0x1234 ->
//    next cycle busy=0, done=0, lut_valid=0, all stats 0.
//    A later start restarts from addr 0x0000.
//  5 Pulse start again at addr 0x0100 during a sweep -> no effect.
//    Entries stay strictly sequential and final stats match test 1.
//  6 LAT=2 with a 2-stage registered exact-adder model ->
//    each DRIVE phase lasts 3 cycles and the captured data equals A+B for every entry.
//    ep_cnt=0 and the full sweep takes 262144 cycles.

Source files
------------

// File: rtl/approx_add_sweep_ctrl_if.sv
// LUT-entry stream from the sweep sequencer to the LUT writer (valid/ready).
interface approx_add_sweep_ctrl_if #(
    parameter int W = 8
);
    logic             lut_valid;
    logic             lut_ready;
    logic [2*W-1:0]   lut_addr;
    logic [W:0]       lut_data;

    modport master (
        output lut_valid,
        output lut_addr,
        output lut_data,
        input  lut_ready
    );

    modport slave (
        input  lut_valid,
        input  lut_addr,
        input  lut_data,
        output lut_ready
    );
endinterface

// File: rtl/approx_add_sweep_ctrl.sv
// Exhaustive operand sweep of one approximate adder: drives {A,B}, captures the sum,
// accumulates error statistics and streams every {A,B} -> O pair as a LUT entry.
module approx_add_sweep_ctrl #(
    parameter int W     = 8,
    parameter int LAT   = 0,
    parameter int ACC_W = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic [W-1:0]         dut_a,
    output logic [W-1:0]         dut_b,
    input  logic [W:0]           dut_o,
    approx_add_sweep_ctrl_if.master lut,
    output logic [2*W:0]         ep_cnt,
    output logic [W:0]           wce,
    output logic [ACC_W-1:0]     sae
);
    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;

    typedef enum logic [1:0] {IDLE, DRIVE, EMIT, DONE} state_t;

    state_t           state, state_nx;
    logic [2*W-1:0]   vec;
    logic [CW-1:0]    lat_cnt;
    logic             last_drive;
    logic             vec_last;
    logic [W:0]       exact;
    logic [W:0]       err;

    // A is the upper half of the sweep counter so B wraps into A
    assign dut_a      = vec[2*W-1:W];
    assign dut_b      = vec[W-1:0];
    assign last_drive = (lat_cnt == CW'(LAT));
    assign vec_last   = &vec;
    assign exact      = {1'b0, dut_a} + {1'b0, dut_b};
    assign err        = (dut_o >= exact) ? (dut_o - exact) : (exact - dut_o);

    always_comb begin
        state_nx      = state;
        busy          = 1'b0;
        done          = 1'b0;
        lut.lut_valid = 1'b0;
        case (state)
            IDLE, DONE: begin
                done = (state == DONE);
                if (start) state_nx = DRIVE;
            end
            DRIVE: begin
                busy = 1'b1;
                if (last_drive) state_nx = EMIT;
            end
            EMIT: begin
                busy          = 1'b1;
                lut.lut_valid = 1'b1;
                if (lut.lut_ready) state_nx = vec_last ? DONE : DRIVE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vec          <= '0;
            lat_cnt      <= '0;
            lut.lut_addr <= '0;
            lut.lut_data <= '0;
            ep_cnt       <= '0;
            wce          <= '0;
            sae          <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        vec     <= '0;
                        lat_cnt <= '0;
                        ep_cnt  <= '0;
                        wce     <= '0;
                        sae     <= '0;
                    end
                end
                DRIVE: begin
                    if (last_drive) begin
                        lat_cnt      <= '0;
                        lut.lut_addr <= vec;
                        lut.lut_data <= dut_o;
                        if (err != '0) ep_cnt <= ep_cnt + (2*W+1)'(1);
                        if (err > wce) wce <= err;
                        sae <= sae + ACC_W'(err);
                    end else begin
                        lat_cnt <= lat_cnt + CW'(1);
                    end
                end
                EMIT: begin
                    if (lut.lut_ready && !vec_last) vec <= vec + (2*W)'(1);
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_approx_add_sweep_ctrl.sv
// Scoreboard bench: two sequencers (LAT=0 and LAT=2) against table-driven adder models.
module tb_approx_add_sweep_ctrl;
    localparam int W     = 4;
    localparam int N     = 1 << (2 * W);
    localparam int ACC_W = 16;

    typedef struct {
        int     addr;
        int     data;
        int     ep;
        int     wce;
        longint sae;
    } ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start0 = 1'b0, start2 = 1'b0;
    logic busy0, done0, busy2, done2;
    logic [W-1:0] a0, b0, a2, b2;
    logic [W:0]   o0, o2, p1, p2;
    logic [2*W:0] ep0, ep2;
    logic [W:0]   wce0, wce2;
    logic [ACC_W-1:0] sae0, sae2;

    int   mode0 = 0, mode2 = 0;
    bit   hold0 = 0, rnd0 = 0, rnd2 = 0;
    logic [W:0] rnd_tab [N];
    ent_t q0[$], q2[$];
    ent_t e0, e2;
    int   n_cmp = 0, n_bad = 0;
    int   tot_ep, tot_wce;
    longint tot_sae;
    int   cyc;

    always #5 clk = ~clk;

    approx_add_sweep_ctrl_if #(.W(W)) l0 ();
    approx_add_sweep_ctrl_if #(.W(W)) l2 ();

    function automatic int ref_sum(input int m, input int a, input int b);
        case (m)
            0:       return a + b;
            1:       return (a + b) & ~1;
            default: return int'(rnd_tab[a * (1 << W) + b]);
        endcase
    endfunction

    assign o0 = (W+1)'(ref_sum(mode0, int'(a0), int'(b0)));
    always_ff @(posedge clk) begin
        p1 <= (W+1)'(ref_sum(mode2, int'(a2), int'(b2)));
        p2 <= p1;
    end
    assign o2 = p2;

    approx_add_sweep_ctrl #(.W(W), .LAT(0), .ACC_W(ACC_W)) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .busy(busy0), .done(done0),
        .dut_a(a0), .dut_b(b0), .dut_o(o0), .lut(l0.master),
        .ep_cnt(ep0), .wce(wce0), .sae(sae0)
    );

    approx_add_sweep_ctrl #(.W(W), .LAT(2), .ACC_W(ACC_W)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
        .dut_a(a2), .dut_b(b2), .dut_o(o2), .lut(l2.master),
        .ep_cnt(ep2), .wce(wce2), .sae(sae2)
    );

    task automatic chk(input string nm, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Expected entries with running statistics, straight from |O - (A+B)| per pair
    task automatic build(input int which, input int m);
        int     ep = 0, wc = 0;
        longint sa = 0;
        ent_t   e;
        for (int i = 0; i < N; i++) begin
            int a = i >> W;
            int b = i % (1 << W);
            int s = ref_sum(m, a, b);
            int d = (s > a + b) ? s - (a + b) : (a + b) - s;
            if (d != 0) ep++;
            if (d > wc) wc = d;
            sa += d;
            e = '{i, s, ep, wc, sa};
            if (which == 0) q0.push_back(e);
            else            q2.push_back(e);
        end
        tot_ep  = ep;
        tot_wce = wc;
        tot_sae = sa;
    endtask

    always @(posedge clk) begin
        #1;
        l0.lut_ready = hold0 ? 1'b0 : (rnd0 ? ($urandom_range(3) != 0) : 1'b1);
        l2.lut_ready = rnd2 ? ($urandom_range(2) != 0) : 1'b1;
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && l0.lut_valid === 1'b1 && l0.lut_ready === 1'b1) begin
            if (q0.size() == 0) begin
                chk("lut0_unexpected_entry", 1, 0);
            end else begin
                e0 = q0.pop_front();
                chk("lut0_addr", l0.lut_addr, e0.addr);
                chk("lut0_data", l0.lut_data, e0.data);
                chk("lut0_ep_cnt", ep0, e0.ep);
                chk("lut0_wce", wce0, e0.wce);
                chk("lut0_sae", sae0, e0.sae);
            end
        end
    end

    always @(negedge clk) begin
        if (rst === 1'b0 && l2.lut_valid === 1'b1 && l2.lut_ready === 1'b1) begin
            if (q2.size() == 0) begin
                chk("lut2_unexpected_entry", 1, 0);
            end else begin
                e2 = q2.pop_front();
                chk("lut2_addr", l2.lut_addr, e2.addr);
                chk("lut2_data", l2.lut_data, e2.data);
                chk("lut2_ep_cnt", ep2, e2.ep);
                chk("lut2_wce", wce2, e2.wce);
                chk("lut2_sae", sae2, e2.sae);
            end
        end
    end

    task automatic go(input int which, input int m);
        @(posedge clk); #1;
        build(which, m);
        if (which == 0) start0 = 1'b1;
        else            start2 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        start2 = 1'b0;
    endtask

    task automatic wait_done(input int which, output int c);
        c = 0;
        while (1) begin
            @(posedge clk); #1;
            c++;
            if (((which == 0) ? done0 : done2) || c >= 20000) break;
        end
        chk("done_reached", (which == 0) ? done0 : done2, 1);
        chk("queue_drained", (which == 0) ? q0.size() : q2.size(), 0);
    endtask

    task automatic wait_vec(input int v);
        int k = 0;
        do begin
            @(negedge clk);
            k++;
        end while (!({a0, b0} == v && busy0 && !l0.lut_valid) && k < 5000);
        chk("reach_vec", {a0, b0}, v);
    endtask

    task automatic fill_rnd();
        for (int i = 0; i < N; i++) begin
            int s = (i >> W) + (i % (1 << W));
            rnd_tab[i] = ($urandom_range(2) == 0) ? (W+1)'($urandom_range((1 << (W+1)) - 1))
                                                  : (W+1)'(s);
        end
    endtask

    initial begin
        fill_rnd();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy0, 0);
        chk("rst_done", done0, 0);
        chk("rst_valid", l0.lut_valid, 0);
        chk("rst_ab", {a0, b0}, 0);
        chk("rst_addr_data", {l0.lut_addr, l0.lut_data}, 0);
        chk("rst_stats", {ep0, wce0, sae0}, 0);
        rst = 1'b0;

        // exact adder, full throughput
        mode0 = 0;
        go(0, 0);
        wait_done(0, cyc);
        chk("t1_cycles", cyc, 2 * N);
        chk("t1_stats", {ep0, wce0, sae0}, 0);
        chk("t1_busy", busy0, 0);

        // LSB-dropping adder
        mode0 = 1;
        go(0, 1);
        wait_done(0, cyc);
        chk("t2_ep_cnt", ep0, N / 2);
        chk("t2_wce", wce0, 1);
        chk("t2_sae", sae0, N / 2);

        // back-pressure at entry 3
        go(0, 1);
        wait_vec(3);
        hold0 = 1;
        @(posedge clk);
        repeat (5) begin
            @(negedge clk);
            chk("bp_valid", l0.lut_valid, 1);
            chk("bp_addr", l0.lut_addr, 3);
            chk("bp_data", l0.lut_data, 2);
            chk("bp_ab", {a0, b0}, 3);
        end
        hold0 = 0;
        wait_done(0, cyc);

        // start while busy is ignored
        mode0 = 0;
        go(0, 0);
        wait_vec(8'h10);
        @(posedge clk); #1;
        start0 = 1'b1;
        @(posedge clk); #1;
        start0 = 1'b0;
        wait_done(0, cyc);
        chk("t5_stats", {ep0, wce0, sae0}, 0);

        // reset mid-sweep, then full random sweep with random back-pressure
        fill_rnd();
        mode0 = 2;
        go(0, 2);
        wait_vec(8'h12);
        @(posedge clk); #1;
        chk("t4_pre_addr", l0.lut_addr, 8'h12);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        chk("t4_busy", busy0, 0);
        chk("t4_done", done0, 0);
        chk("t4_valid", l0.lut_valid, 0);
        chk("t4_stats", {ep0, wce0, sae0}, 0);
        chk("t4_ab_addr", {a0, b0, l0.lut_addr, l0.lut_data}, 0);
        q0.delete();
        rnd0 = 1;
        go(0, 2);
        wait_done(0, cyc);
        chk("t4_final_ep", ep0, tot_ep);
        chk("t4_final_wce", wce0, tot_wce);
        chk("t4_final_sae", sae0, tot_sae);
        rnd0 = 0;

        // LAT=2 with a two-stage registered adder model
        mode2 = 0;
        go(1, 0);
        wait_done(1, cyc);
        chk("t6_cycles", cyc, 4 * N);
        chk("t6_ep_cnt", ep2, 0);

        fill_rnd();
        mode2 = 2;
        rnd2 = 1;
        go(1, 2);
        wait_done(1, cyc);
        chk("t6r_ep", ep2, tot_ep);
        chk("t6r_wce", wce2, tot_wce);
        chk("t6r_sae", sae2, tot_sae);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
